// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with ALU-op decode and operand
// forwarding.
//
// A single-entry elastic register between decode and execute. An instruction
// is captured when in_valid && in_ready && !flush; the ALU op is decoded at
// capture time and held registered. Operands seen by the ALU are forwarded
// combinationally from the EX/MEM and MEM/WB result buses.
//
// Optional feature macro: FORWARD_EN
//   defined   : EX/MEM > MEM/WB > held-data forwarding (never for x0), plus
//               write-back refresh of held operands while stalled.
//   undefined : held data is presented directly; forwarding ports ignored.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           decode-side handshake
//   rs1_data, rs2_data, imm       operands and sign-extended immediate
//   rs1_addr, rs2_addr, rd_addr   register indices
//   alu_src, alu_ctrl, funct3,
//   funct7_5                      ALU control from decode
//   flush                         squash held / incoming instruction
//   exmem_*, memwb_*              forwarding sources
//   out_valid / out_ready         ALU-side handshake
//   alu_in1, alu_in2, store_data  ALU operands and store data
//   alu_op, rd_out, illegal_op    decoded op, destination, illegal flag
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic            alu_src,
    input  logic [1:0]      alu_ctrl,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            flush,
    input  logic            exmem_we,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_we,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] store_data,
    output logic [3:0]      alu_op,
    output logic [4:0]      rd_out,
    output logic            illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    // Returns {illegal, alu_op}.
    function automatic logic [4:0] decode(input logic [1:0] ctrl,
                                          input logic [2:0] f3,
                                          input logic       f7);
        logic [4:0] r;
        r = {1'b0, OP_ADD};
        case (ctrl)
            2'b00: r = {1'b0, OP_ADD};
            2'b01: r = {1'b0, OP_SUB};
            default: begin
                case (f3)
                    // funct7_5 selects SUB only for R-type; I-type ignores it.
                    3'b000:  r = {1'b0, (ctrl == 2'b10 && f7) ? OP_SUB : OP_ADD};
                    3'b111:  r = {1'b0, OP_AND};
                    3'b110:  r = {1'b0, OP_OR};
                    3'b010:  r = {1'b0, OP_SLT};
                    default: r = {1'b1, OP_ADD};
                endcase
            end
        endcase
        return r;
    endfunction

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] rs1_q,     rs1_d;
    logic [XLEN-1:0] rs2_q,     rs2_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    logic [4:0]      rs1a_q,    rs1a_d;
    logic [4:0]      rs2a_q,    rs2a_d;
    logic [4:0]      rd_q,      rd_d;
    logic            src_q,     src_d;
    logic [3:0]      op_q,      op_d;
    logic            ill_q,     ill_d;

    logic capture;
    logic hold;
    logic [4:0] dec;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready;
    assign dec      = decode(alu_ctrl, funct3, funct7_5);

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        rs1a_d  = rs1a_q;
        rs2a_d  = rs2a_q;
        rd_d    = rd_q;
        src_d   = src_q;
        op_d    = op_q;
        ill_d   = ill_q;

        // Flush wins over capture; drain-plus-capture keeps valid high.
        if (flush)          valid_d = 1'b0;
        else if (capture)   valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;

        if (capture) begin
            rs1_d  = rs1_data;
            rs2_d  = rs2_data;
            imm_d  = imm;
            rs1a_d = rs1_addr;
            rs2a_d = rs2_addr;
            rd_d   = rd_addr;
            src_d  = alu_src;
            op_d   = dec[3:0];
            ill_d  = dec[4];
        end
`ifdef FORWARD_EN
        // A stalled entry would miss a write-back that retires while it
        // waits, so fold the MEM/WB result into the held operand.
        else if (hold) begin
            if (memwb_we && memwb_rd == rs1a_q && rs1a_q != 5'd0) rs1_d = memwb_result;
            if (memwb_we && memwb_rd == rs2a_q && rs2a_q != 5'd0) rs2_d = memwb_result;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rs1a_q  <= '0;
            rs2a_q  <= '0;
            rd_q    <= '0;
            src_q   <= 1'b0;
            op_q    <= OP_ADD;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rs1a_q  <= rs1a_d;
            rs2a_q  <= rs2a_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
        end
    end

    logic [XLEN-1:0] op1, op2;

`ifdef FORWARD_EN
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      addr,
                                            input logic [XLEN-1:0] held);
        logic [XLEN-1:0] v;
        v = held;
        if (addr != 5'd0) begin
            if (exmem_we && exmem_rd == addr)      v = exmem_result;
            else if (memwb_we && memwb_rd == addr) v = memwb_result;
        end
        return v;
    endfunction

    assign op1 = fwd(rs1a_q, rs1_q);
    assign op2 = fwd(rs2a_q, rs2_q);
    logic unused_hold;
    assign unused_hold = hold;
`else
    assign op1 = rs1_q;
    assign op2 = rs2_q;
    logic unused_fwd;
    assign unused_fwd = ^{exmem_we, exmem_rd, exmem_result, memwb_we,
                          memwb_rd, memwb_result, rs1a_q, rs2a_q, hold};
`endif

    assign out_valid  = valid_q;
    assign alu_in1    = op1;
    assign alu_in2    = src_q ? imm_q : op2;
    assign store_data = op2;
    assign alu_op     = op_q;
    assign rd_out     = rd_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr;
    logic            alu_src;
    logic [1:0]      alu_ctrl;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            flush;
    logic            exmem_we;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_we;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_in1, alu_in2, store_data;
    logic [3:0]      alu_op;
    logic [4:0]      rd_out;
    logic            illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .funct3(funct3), .funct7_5(funct7_5),
        .flush(flush),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .store_data(store_data),
        .alu_op(alu_op), .rd_out(rd_out), .illegal_op(illegal_op)
    );

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        rs1_data = 64'hDEAD; rs2_data = 64'hBEEF; imm = 64'h77;
        rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd7;
        alu_src = 1'b0; alu_ctrl = 2'b10; funct3 = 3'b001; funct7_5 = 1'b1;
        exmem_we = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_result = '0;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
        total++; if (alu_op !== 4'b0010) begin bad++; $display("FAIL rst_aluop got=%0h want=2", alu_op); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0h want=0", illegal_op); end
        total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0h want=0", rd_out); end
        total++; if (alu_in1 !== 64'h0 || alu_in2 !== 64'h0 || store_data !== 64'h0) begin
            bad++; $display("FAIL rst_data got=%0h/%0h/%0h want=0/0/0", alu_in1, alu_in2, store_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_inready got=%0h want=1", in_ready); end
    endtask

    task automatic test_itype_capture();
        in_valid = 1'b1; out_ready = 1'b0;
        rs1_data = 64'd5; rs2_data = 64'd9; imm = 64'd7;
        rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd9;
        alu_src = 1'b1; alu_ctrl = 2'b11; funct3 = 3'b000; funct7_5 = 1'b0;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL itype_valid got=%0h want=1", out_valid); end
        total++; if (alu_in1 !== 64'd5) begin bad++; $display("FAIL itype_in1 got=%0h want=5", alu_in1); end
        total++; if (alu_in2 !== 64'd7) begin bad++; $display("FAIL itype_in2 got=%0h want=7", alu_in2); end
        total++; if (alu_op !== 4'b0010) begin bad++; $display("FAIL itype_op got=%0h want=2", alu_op); end
        total++; if (rd_out !== 5'd9) begin bad++; $display("FAIL itype_rd got=%0h want=9", rd_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL itype_inready got=%0h want=0", in_ready); end
    endtask

    task automatic test_hold();
        // New instruction presented while stalled must not be taken.
        in_valid = 1'b1; rs1_data = 64'h99; imm = 64'h98; rd_addr = 5'd3;
        alu_ctrl = 2'b01;
        step(); step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0h want=1", out_valid); end
        total++; if (alu_in1 !== 64'd5 || alu_in2 !== 64'd7) begin
            bad++; $display("FAIL hold_data got=%0h/%0h want=5/7", alu_in1, alu_in2); end
        total++; if (rd_out !== 5'd9 || alu_op !== 4'b0010) begin
            bad++; $display("FAIL hold_ctrl got=%0h/%0h want=9/2", rd_out, alu_op); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0h want=0", out_valid); end
    endtask

    // {alu_ctrl, funct3, funct7_5, expected alu_op, expected illegal}
    logic [10:0] dvec [11] = '{
        {2'b10, 3'b000, 1'b1, 4'b0110, 1'b0},
        {2'b10, 3'b001, 1'b0, 4'b0010, 1'b1},
        {2'b10, 3'b000, 1'b0, 4'b0010, 1'b0},
        {2'b10, 3'b111, 1'b0, 4'b0000, 1'b0},
        {2'b10, 3'b110, 1'b1, 4'b0001, 1'b0},
        {2'b10, 3'b010, 1'b0, 4'b0111, 1'b0},
        {2'b11, 3'b000, 1'b1, 4'b0010, 1'b0},
        {2'b11, 3'b111, 1'b1, 4'b0000, 1'b0},
        {2'b11, 3'b101, 1'b0, 4'b0010, 1'b1},
        {2'b00, 3'b001, 1'b0, 4'b0010, 1'b0},
        {2'b01, 3'b011, 1'b1, 4'b0110, 1'b0}
    };

    task automatic test_decode();
        logic [10:0] v;
        in_valid = 1'b1; out_ready = 1'b1; alu_src = 1'b0; imm = 64'h1234;
        for (int i = 0; i < 11; i++) begin
            v = dvec[i];
            alu_ctrl = v[10:9]; funct3 = v[8:6]; funct7_5 = v[5];
            rs2_data = 64'h40 + 64'(i); rd_addr = 5'(i);
            step();
            total++; if (alu_op !== v[4:1] || illegal_op !== v[0]) begin
                bad++; $display("FAIL decode_%0d got=op%0h/ill%0h want=op%0h/ill%0h", i, alu_op, illegal_op, v[4:1], v[0]); end
            total++; if (alu_in2 !== 64'h40 + 64'(i)) begin
                bad++; $display("FAIL decode_in2_%0d got=%0h want=%0h", i, alu_in2, 64'h40 + 64'(i)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_forward();
        logic [XLEN-1:0] exp;
        // Drain-plus-capture, then stall.
        in_valid = 1'b1; out_ready = 1'b1; alu_src = 1'b0; alu_ctrl = 2'b10; funct3 = 3'b000;
        rs1_data = 64'h11; rs1_addr = 5'd3; rs2_data = 64'h22; rs2_addr = 5'd0;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_we = 1'b1; exmem_rd = 5'd3; exmem_result = 64'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd3; memwb_result = 64'hBB;
        #1;
`ifdef FORWARD_EN
        exp = 64'hAA;
`else
        exp = 64'h11;
`endif
        total++; if (alu_in1 !== exp) begin bad++; $display("FAIL fwd_exmem got=%0h want=%0h", alu_in1, exp); end
        exmem_we = 1'b0;
        #1;
`ifdef FORWARD_EN
        exp = 64'hBB;
`else
        exp = 64'h11;
`endif
        total++; if (alu_in1 !== exp) begin bad++; $display("FAIL fwd_memwb got=%0h want=%0h", alu_in1, exp); end
        memwb_we = 1'b0;
        #1;
        total++; if (alu_in1 !== 64'h11) begin bad++; $display("FAIL fwd_none got=%0h want=11", alu_in1); end

        // x0 source: never forwarded, even when the buses name register 0.
        in_valid = 1'b1; out_ready = 1'b1; rs1_data = 64'h33; rs1_addr = 5'd0;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_we = 1'b1; exmem_rd = 5'd0; exmem_result = 64'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd0; memwb_result = 64'hBB;
        #1;
        total++; if (alu_in1 !== 64'h33) begin bad++; $display("FAIL fwd_x0 got=%0h want=33", alu_in1); end
        total++; if (store_data !== 64'h22) begin bad++; $display("FAIL fwd_x0_store got=%0h want=22", store_data); end
        exmem_we = 1'b0; memwb_we = 1'b0;
    endtask

    task automatic test_refresh();
        logic [XLEN-1:0] exp;
        in_valid = 1'b1; out_ready = 1'b1; alu_src = 1'b1; imm = 64'h1;
        rs1_data = 64'h9; rs1_addr = 5'd5; rs2_data = 64'h10; rs2_addr = 5'd4;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        memwb_we = 1'b1; memwb_rd = 5'd4; memwb_result = 64'h55;
        step();
        memwb_we = 1'b0; memwb_result = 64'h0;
        step(); step();
`ifdef FORWARD_EN
        exp = 64'h55;
`else
        exp = 64'h10;
`endif
        total++; if (store_data !== exp) begin bad++; $display("FAIL refresh_store got=%0h want=%0h", store_data, exp); end
        total++; if (alu_in1 !== 64'h9 || alu_in2 !== 64'h1) begin
            bad++; $display("FAIL refresh_other got=%0h/%0h want=9/1", alu_in1, alu_in2); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL refresh_valid got=%0h want=1", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1; alu_src = 1'b0; alu_ctrl = 2'b00;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        for (int i = 0; i < 4; i++) begin
            rs1_data = 64'd100 + 64'(i); rd_addr = 5'(i + 1);
            step();
            total++; if (out_valid !== 1'b1 || alu_in1 !== 64'd100 + 64'(i) || rd_out !== 5'(i + 1)) begin
                bad++; $display("FAIL b2b_%0d got=v%0h/%0h/rd%0h want=v1/%0h/rd%0h", i, out_valid, alu_in1, rd_out, 64'd100 + 64'(i), i + 1); end
        end
        flush = 1'b1; rs1_data = 64'd200;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", out_valid); end
        flush = 1'b0; in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_nocapture got=%0h want=0", out_valid); end
        // Flush while stalled also squashes the held entry.
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%0h want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_itype_capture();
        test_hold();
        test_decode();
        test_forward();
        test_refresh();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
